// File: rtl/pong_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : pong_score_keeper
// Description : Pong point counter and match-flow controller (IDLE/PLAY/HOLD/
//               OVER) driving BCD score digits and ball freeze/serve controls.
//               Optional macro SCORE_SYNC_EN adds 2-flop input synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_score_keeper #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_CYCLES = 25000000,
    parameter int HOLD_W      = 25
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       start,
    input  logic       score_p1,
    input  logic       score_p2,
    output logic [3:0] first,
    output logic [3:0] second,
    output logic       freeze,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0]        c_win_score = WIN_SCORE[3:0];
    localparam logic [HOLD_W-1:0] c_hold_load = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HOLD = 2'd2,
        S_OVER = 2'd3
    } state_t;

    // Bit order everywhere below: {start, score_p2, score_p1}
    logic [2:0] w_in_raw;
    logic [2:0] w_in;
    assign w_in_raw = {start, score_p2, score_p1};

`ifdef SCORE_SYNC_EN
    logic [2:0] r_sync_meta;
    logic [2:0] r_sync_out;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_sync_meta <= '0;
            r_sync_out  <= '0;
        end else begin
            r_sync_meta <= w_in_raw;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_in = r_sync_out;
`else
    assign w_in = w_in_raw;
`endif

    logic [2:0] r_prev;
    logic [2:0] w_rise;
    logic       w_start_rise;
    logic       w_p1_rise;
    logic       w_p2_rise;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_in;
        end
    end

    assign w_rise       = w_in & ~r_prev;
    assign w_p1_rise    = w_rise[0];
    assign w_p2_rise    = w_rise[1];
    assign w_start_rise = w_rise[2];

    state_t            r_state;
    logic [3:0]        r_first;
    logic [3:0]        r_second;
    logic              r_freeze;
    logic              r_serve_dir;
    logic              r_game_over;
    logic              r_winner;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [3:0]        w_first_inc;
    logic [3:0]        w_second_inc;

    assign w_first_inc  = r_first + 4'd1;
    assign w_second_inc = r_second + 4'd1;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_first     <= 4'd0;
            r_second    <= 4'd0;
            r_freeze    <= 1'b1;
            r_serve_dir <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_freeze <= 1'b1;
                    if (w_start_rise) begin
                        r_first  <= 4'd0;
                        r_second <= 4'd0;
                        r_freeze <= 1'b0;
                        r_state  <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    // freeze rises on the same edge as the score update so the
                    // ball logic never sees a live cycle after a point
                    if (w_p1_rise && w_p2_rise) begin
                        r_serve_dir <= ~r_serve_dir;
                        r_hold_cnt  <= c_hold_load;
                        r_freeze    <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_p1_rise) begin
                        r_first  <= w_first_inc;
                        r_freeze <= 1'b1;
                        if (w_first_inc == c_win_score) begin
                            r_winner    <= 1'b0;
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_serve_dir <= 1'b0;
                            r_hold_cnt  <= c_hold_load;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_p2_rise) begin
                        r_second <= w_second_inc;
                        r_freeze <= 1'b1;
                        if (w_second_inc == c_win_score) begin
                            r_winner    <= 1'b1;
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_serve_dir <= 1'b1;
                            r_hold_cnt  <= c_hold_load;
                            r_state     <= S_HOLD;
                        end
                    end else begin
                        r_freeze <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_freeze <= 1'b0;
                        r_state  <= S_PLAY;
                    end else begin
                        r_freeze   <= 1'b1;
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end

                S_OVER: begin
                    r_freeze <= 1'b1;
                    if (w_start_rise) begin
                        r_first     <= 4'd0;
                        r_second    <= 4'd0;
                        r_game_over <= 1'b0;
                        r_serve_dir <= 1'b0;
                        r_freeze    <= 1'b0;
                        r_state     <= S_PLAY;
                    end
                end

                default: begin
                    r_freeze <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign first     = r_first;
    assign second    = r_second;
    assign freeze    = r_freeze;
    assign serve_dir = r_serve_dir;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_score_keeper
// Description : Directed self-checking bench for pong_score_keeper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_score_keeper;

    localparam int WIN_SCORE   = 9;
    localparam int HOLD_CYCLES = 8;
    localparam int HOLD_W      = 4;
`ifdef SCORE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk25 = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       score_p1 = 1'b0;
    logic       score_p2 = 1'b0;
    logic [3:0] first;
    logic [3:0] second;
    logic       freeze;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk25 = ~clk25;

    pong_score_keeper #(
        .WIN_SCORE  (WIN_SCORE),
        .HOLD_CYCLES(HOLD_CYCLES),
        .HOLD_W     (HOLD_W)
    ) u_dut (
        .clk25    (clk25),
        .reset    (reset),
        .start    (start),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .first    (first),
        .second   (second),
        .freeze   (freeze),
        .serve_dir(serve_dir),
        .game_over(game_over),
        .winner   (winner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk25);
            #1;
        end
    endtask

    // pulse for one cycle, then wait until the result is visible
    task automatic pulse_p1();
        score_p1 = 1'b1;
        tick(1);
        score_p1 = 1'b0;
        tick(LAT - 1);
    endtask

    task automatic pulse_p2();
        score_p2 = 1'b1;
        tick(1);
        score_p2 = 1'b0;
        tick(LAT - 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(LAT - 1);
    endtask

    initial begin
        // reset state
        tick(3);
        check("rst_first",     32'(first),     32'd0);
        check("rst_second",    32'(second),    32'd0);
        check("rst_freeze",    32'(freeze),    32'd1);
        check("rst_serve_dir", 32'(serve_dir), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_winner",    32'(winner),    32'd0);
        reset = 1'b1;
        tick(2);
        check("idle_freeze", 32'(freeze), 32'd1);

        // start pulse -> PLAY
        pulse_start();
        check("start_freeze", 32'(freeze), 32'd0);
        check("start_first",  32'(first),  32'd0);
        check("start_second", 32'(second), 32'd0);

        // score_p1 held 10 cycles: counts once, HOLD lasts HOLD_CYCLES
        for (int i = 0; i < 16; i++) begin
            score_p1 = (i < 10);
            tick(1);
            if (i == LAT - 1) begin
                check("p1_held_first",     32'(first),     32'd1);
                check("p1_held_freeze",    32'(freeze),    32'd1);
                check("p1_held_serve_dir", 32'(serve_dir), 32'd0);
            end
            if (i == LAT - 1 + HOLD_CYCLES - 1)
                check("hold_last_freeze", 32'(freeze), 32'd1);
            if (i == LAT - 1 + HOLD_CYCLES)
                check("hold_end_freeze", 32'(freeze), 32'd0);
        end
        score_p1 = 1'b0;
        check("p1_held_once", 32'(first), 32'd1);

        // simultaneous edges: no score change, serve toggles, HOLD
        score_p1 = 1'b1;
        score_p2 = 1'b1;
        tick(1);
        score_p1 = 1'b0;
        score_p2 = 1'b0;
        tick(LAT - 1);
        check("both_first",     32'(first),     32'd1);
        check("both_second",    32'(second),    32'd0);
        check("both_serve_dir", 32'(serve_dir), 32'd1);
        check("both_freeze",    32'(freeze),    32'd1);
        tick(HOLD_CYCLES);
        check("both_hold_end", 32'(freeze), 32'd0);

        // nine player-2 points to win
        for (int k = 1; k <= WIN_SCORE; k++) begin
            pulse_p2();
            check($sformatf("p2_pt%0d_second", k), 32'(second), 32'(k));
            check($sformatf("p2_pt%0d_freeze", k), 32'(freeze), 32'd1);
            if (k < WIN_SCORE) begin
                check($sformatf("p2_pt%0d_serve", k), 32'(serve_dir), 32'd1);
                tick(HOLD_CYCLES);
                check($sformatf("p2_pt%0d_resume", k), 32'(freeze), 32'd0);
            end
        end
        check("over_game_over", 32'(game_over), 32'd1);
        check("over_winner",    32'(winner),    32'd1);
        check("over_first",     32'(first),     32'd1);

        // scoring ignored in OVER
        pulse_p1();
        tick(2);
        pulse_p2();
        tick(2);
        check("over_hold_first",  32'(first),     32'd1);
        check("over_hold_second", 32'(second),    32'd9);
        check("over_hold_go",     32'(game_over), 32'd1);
        check("over_hold_freeze", 32'(freeze),    32'd1);

        // restart from OVER
        pulse_start();
        check("restart_first",     32'(first),     32'd0);
        check("restart_second",    32'(second),    32'd0);
        check("restart_game_over", 32'(game_over), 32'd0);
        check("restart_freeze",    32'(freeze),    32'd0);
        check("restart_serve_dir", 32'(serve_dir), 32'd0);

        // four player-1 points, reset 3 cycles into the last HOLD
        for (int k = 1; k <= 4; k++) begin
            pulse_p1();
            check($sformatf("p1_pt%0d_first", k), 32'(first), 32'(k));
            if (k < 4) tick(HOLD_CYCLES);
        end
        tick(3);
        check("midhold_freeze", 32'(freeze), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_first",     32'(first),     32'd0);
        check("async_rst_freeze",    32'(freeze),    32'd1);
        check("async_rst_serve_dir", 32'(serve_dir), 32'd0);
        check("async_rst_winner",    32'(winner),    32'd0);
        tick(2);
        reset = 1'b1;
        tick(HOLD_CYCLES + 2);
        check("post_rst_idle_freeze", 32'(freeze), 32'd1);
        pulse_p1();
        tick(2);
        check("idle_ignores_score", 32'(first), 32'd0);
        pulse_start();
        check("post_rst_play", 32'(freeze), 32'd0);
        pulse_p1();
        check("post_rst_score", 32'(first), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
